// File: rtl/led_bank_pkg.sv
// Shared definitions for the multi-channel LED driver: channel mode codes
// and a helper that screens out reserved mode encodings.
package led_bank_pkg;

   localparam int MODE_W = 3;

   typedef enum logic [MODE_W-1:0] {
      MODE_OFF     = 3'd0,
      MODE_ON      = 3'd1,
      MODE_BLINK   = 3'd2,
      MODE_PWM     = 3'd3,
      MODE_ONESHOT = 3'd4
   } mode_e;

   // Reserved codes (5..7) are folded to OFF so they never drive an output.
   function automatic mode_e decode_mode(input logic [MODE_W-1:0] code);
      mode_e m;
      case (code)
         3'd1:    m = MODE_ON;
         3'd2:    m = MODE_BLINK;
         3'd3:    m = MODE_PWM;
         3'd4:    m = MODE_ONESHOT;
         default: m = MODE_OFF;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/led_bank_tick_gen.sv
// Shared prescaler: counts clk cycles 0..PRESCALE-1 and emits a registered
// one-cycle tick the cycle after the count reaches its last value.
module tick_gen #(
   parameter int PRESCALE = 750
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] count;

   // Free-running prescale counter; tick is registered off the wrap point.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
         tick  <= 1'b0;
      end else if (count == LAST) begin
         count <= '0;
         tick  <= 1'b1;
      end else begin
         count <= count + PW'(1);
         tick  <= 1'b0;
      end
   end

endmodule

// File: rtl/led_bank.sv
// Multi-channel LED driver. Each channel has its own mode, period and duty
// registers and advances on the shared prescaler tick. Outputs are registered
// from the current channel state, so they lag state changes by one edge.
module led_bank
   import led_bank_pkg::*;
#(
   parameter int CHANNELS = 5,
   parameter int CNT_W    = 16,
   parameter int PRESCALE = 750,
   localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                wr_en,
   input  logic [CH_W-1:0]     wr_ch,
   input  logic [MODE_W-1:0]   wr_mode,
   input  logic [CNT_W-1:0]    wr_period,
   input  logic [CNT_W-1:0]    wr_duty,
   output logic [CHANNELS-1:0] led,
   output logic                tick,
   output logic [CHANNELS-1:0] active
);

   logic wr_ok;

   // Out-of-range channel indices are dropped here so no channel sees them.
   assign wr_ok = wr_en && (int'(wr_ch) < CHANNELS);

   tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      mode_e            mode_q, mode_d;
      logic [CNT_W-1:0] per_q, per_d;
      logic [CNT_W-1:0] duty_q, duty_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             phase_q, phase_d;
      logic             sel;
      logic             at_end;
      logic [CNT_W-1:0] cnt_step;
      logic             last_shot;
      logic             led_nx;
      logic             led_q;
      logic             active_q;

      assign sel       = wr_ok && (wr_ch == CH_W'(g));
      assign at_end    = (cnt_q == per_q);
      assign cnt_step  = at_end ? '0 : (cnt_q + CNT_W'(1));
      assign last_shot = (({1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1}) == {1'b0, duty_q});

      // Channel next state: a write wins over a tick; otherwise the mode decides.
      always_comb begin
         mode_d  = mode_q;
         per_d   = per_q;
         duty_d  = duty_q;
         cnt_d   = cnt_q;
         phase_d = phase_q;
         if (sel) begin
            mode_d  = decode_mode(wr_mode);
            per_d   = wr_period;
            duty_d  = wr_duty;
            cnt_d   = '0;
            phase_d = 1'b0;
         end else begin
            case (mode_q)
               MODE_OFF: begin
                  cnt_d = '0;
               end
               MODE_ON, MODE_PWM: begin
                  if (tick) begin
                     cnt_d = cnt_step;
                  end else begin
                     cnt_d = cnt_q;
                  end
               end
               MODE_BLINK: begin
                  if (tick) begin
                     cnt_d   = cnt_step;
                     phase_d = at_end ? ~phase_q : phase_q;
                  end else begin
                     cnt_d = cnt_q;
                  end
               end
               MODE_ONESHOT: begin
                  // A zero-length shot retires immediately without waiting for a tick.
                  if (duty_q == '0) begin
                     mode_d = MODE_OFF;
                     cnt_d  = '0;
                  end else if (tick && last_shot) begin
                     mode_d = MODE_OFF;
                     cnt_d  = '0;
                  end else if (tick) begin
                     cnt_d = cnt_step;
                  end else begin
                     cnt_d = cnt_q;
                  end
               end
               default: begin
                  mode_d = MODE_OFF;
                  cnt_d  = '0;
               end
            endcase
         end
      end

      // Output value implied by the current channel state.
      always_comb begin
         led_nx = 1'b0;
         case (mode_q)
            MODE_OFF:     led_nx = 1'b0;
            MODE_ON:      led_nx = 1'b1;
            MODE_BLINK:   led_nx = phase_q;
            MODE_PWM:     led_nx = (cnt_q < duty_q);
            MODE_ONESHOT: led_nx = (cnt_q < duty_q);
            default:      led_nx = 1'b0;
         endcase
      end

      // Channel state and registered outputs.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            mode_q   <= MODE_OFF;
            per_q    <= '0;
            duty_q   <= '0;
            cnt_q    <= '0;
            phase_q  <= 1'b0;
            led_q    <= 1'b0;
            active_q <= 1'b0;
         end else begin
            mode_q   <= mode_d;
            per_q    <= per_d;
            duty_q   <= duty_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            led_q    <= led_nx;
            active_q <= (mode_q != MODE_OFF);
         end
      end

      assign led[g]    = led_q;
      assign active[g] = active_q;
   end

endmodule

// File: tb/tb_led_bank.sv
// Scoreboard bench for led_bank. A reference model tracks, per channel, the
// configured mode and the number of ticks elapsed since it was written, and
// derives the expected outputs arithmetically from that count.
module tb_led_bank;

   localparam int CH  = 5;
   localparam int CW  = 8;
   localparam int PRE = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wr_en = 1'b0;
   logic [2:0]    wr_ch = 3'd0;
   logic [2:0]    wr_mode = 3'd0;
   logic [CW-1:0] wr_period = '0;
   logic [CW-1:0] wr_duty = '0;
   logic [CH-1:0] led;
   logic          tick;
   logic [CH-1:0] active;

   int vectors = 0;
   int miscompares = 0;

   typedef struct packed {
      logic [CH-1:0] led;
      logic [CH-1:0] active;
      logic          tick;
   } exp_t;

   exp_t exp_q[$];

   led_bank #(.CHANNELS(CH), .CNT_W(CW), .PRESCALE(PRE)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_ch(wr_ch),
      .wr_mode(wr_mode), .wr_period(wr_period), .wr_duty(wr_duty),
      .led(led), .tick(tick), .active(active)
   );

   always #5 clk = ~clk;

   // Reference model state: mode 0..4, period, duty, ticks since the write.
   int m_mode[CH];
   int m_p[CH];
   int m_d[CH];
   int m_k[CH];
   int m_cyc = 0;
   bit m_tick = 1'b0;

   function automatic bit model_led(int ch);
      int len;
      len = m_p[ch] + 1;
      case (m_mode[ch])
         1: return 1'b1;
         2: return ((m_k[ch] / len) % 2) == 1;
         3: return (m_k[ch] % len) < m_d[ch];
         4: return m_d[ch] != 0;
         default: return 1'b0;
      endcase
   endfunction

   // Model step per edge: outputs from pre-edge state, then advance state.
   always @(posedge clk) begin
      exp_t e;
      bit   tick_before;
      e = '0;
      if (!rst_n) begin
         for (int c = 0; c < CH; c++) begin
            m_mode[c] = 0; m_p[c] = 0; m_d[c] = 0; m_k[c] = 0;
         end
         m_cyc  = 0;
         m_tick = 1'b0;
      end else begin
         tick_before = m_tick;
         m_cyc  = m_cyc + 1;
         m_tick = (m_cyc % PRE) == 0;
         e.tick = m_tick;
         for (int c = 0; c < CH; c++) begin
            e.led[c]    = model_led(c);
            e.active[c] = m_mode[c] != 0;
         end
         for (int c = 0; c < CH; c++) begin
            if (wr_en && int'(wr_ch) == c) begin
               m_mode[c] = (int'(wr_mode) <= 4) ? int'(wr_mode) : 0;
               m_p[c] = int'(wr_period);
               m_d[c] = int'(wr_duty);
               m_k[c] = 0;
            end else begin
               if (tick_before && m_mode[c] != 0) m_k[c] = m_k[c] + 1;
               if (m_mode[c] == 4 && m_d[c] <= m_p[c] + 1 && m_k[c] >= m_d[c])
                  m_mode[c] = 0;
            end
         end
      end
      exp_q.push_back(e);
   end

   // Monitor: every cycle presents an output word; compare away from the edge.
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         vectors = vectors + 1;
         if (led !== e.led) begin
            miscompares = miscompares + 1;
            $display("FAIL led t=%0t got=%b exp=%b", $time, led, e.led);
         end
         if (active !== e.active) begin
            miscompares = miscompares + 1;
            $display("FAIL active t=%0t got=%b exp=%b", $time, active, e.active);
         end
         if (tick !== e.tick) begin
            miscompares = miscompares + 1;
            $display("FAIL tick t=%0t got=%b exp=%b", $time, tick, e.tick);
         end
      end
   end

   task automatic do_write(input int ch, input int mode, input int p, input int d);
      @(negedge clk);
      wr_en = 1'b1; wr_ch = 3'(ch); wr_mode = 3'(mode);
      wr_period = CW'(p); wr_duty = CW'(d);
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      bit seen;
      rst_n = 1'b0;
      idle(3);
      rst_n = 1'b1;
      idle(40);

      // Blink, PWM variants, one-shot variants.
      do_write(0, 2, 1, 0);
      idle(40);
      do_write(1, 3, 3, 1);
      idle(40);
      do_write(1, 3, 3, 0);
      idle(20);
      do_write(1, 3, 3, 9);
      idle(20);
      do_write(2, 4, 15, 3);
      idle(24);
      do_write(2, 4, 15, 0);
      idle(12);

      // ON written on the same edge as a tick, then an out-of-range write.
      seen = 1'b0;
      for (int i = 0; i < 3 * PRE && !seen; i++) begin
         @(negedge clk);
         if (tick) seen = 1'b1;
      end
      if (!seen) begin
         miscompares = miscompares + 1;
         $display("FAIL tick_wait no tick within %0d cycles", 3 * PRE);
      end
      wr_en = 1'b1; wr_ch = 3'd3; wr_mode = 3'd1; wr_period = 8'd2; wr_duty = 8'd0;
      @(negedge clk);
      wr_en = 1'b0;
      idle(4);
      do_write(7, 2, 0, 0);
      idle(12);

      // Reset in the middle of a blink and a one-shot.
      do_write(0, 2, 0, 0);
      do_write(2, 4, 30, 20);
      idle(9);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      idle(20);

      // Randomised traffic including reserved modes and out-of-range channels.
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 299) == 0) begin
            rst_n = 1'b0;
         end else begin
            rst_n = 1'b1;
         end
         if ($urandom_range(0, 5) == 0) begin
            wr_en     = 1'b1;
            wr_ch     = 3'($urandom_range(0, 7));
            wr_mode   = 3'($urandom_range(0, 7));
            wr_period = CW'($urandom_range(0, 6));
            wr_duty   = CW'($urandom_range(0, 9));
         end else begin
            wr_en = 1'b0;
         end
      end
      wr_en = 1'b0;
      rst_n = 1'b1;
      idle(5);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
